// File: rtl/reverb_scheduler.sv
// reverb_scheduler: five-channel Schroeder comb bank time-multiplexed over one shared single-port delay RAM.
// Ports: clk, reset (sync, active-high); sample_valid/din sample input; busy, sample_drop status;
//        dout/dout_valid mixed output; mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata RAM port
//        (mem_rdata is valid the cycle after mem_rd).
// Optional: define REVERB_SCHED_CLEAR_EN to zero the whole delay RAM after every reset.
module reverb_scheduler #(
   parameter int                 ADDR_W   = 14,
   parameter int                 D0       = 3000,
   parameter int                 D1       = 5000,
   parameter int                 D2       = 7000,
   parameter int                 D3       = 9000,
   parameter int                 D4       = 11000,
   parameter logic signed [15:0] FEEDBACK = 16'sd22937
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sample_valid,
   input  logic signed [15:0]       din,
   output logic                     busy,
   output logic                     sample_drop,
   output logic signed [15:0]       dout,
   output logic                     dout_valid,
   output logic        [ADDR_W+2:0] mem_addr,
   output logic                     mem_rd,
   output logic                     mem_wr,
   output logic signed [15:0]       mem_wdata,
   input  logic signed [15:0]       mem_rdata
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CALC,
      S_WRITE,
      S_OUT
`ifdef REVERB_SCHED_CLEAR_EN
      , S_CLEAR
`endif
   } state_t;
`ifdef REVERB_SCHED_CLEAR_EN
   localparam state_t S_RST = S_CLEAR;
   localparam logic [ADDR_W+2:0] CLR_N = (ADDR_W+3)'(5 << ADDR_W);
`else
   localparam state_t S_RST = S_IDLE;
`endif
   state_t                r_state;
   logic        [2:0]     r_chan;
   logic        [ADDR_W-1:0] r_wptr;
   logic signed [18:0]    r_acc;
   logic signed [15:0]    r_din, r_dout, r_wdata;
   logic                  r_drop, r_dv, r_rd, r_wr;
   logic        [ADDR_W+2:0] r_addr;
`ifdef REVERB_SCHED_CLEAR_EN
   logic        [ADDR_W+2:0] r_clr;
`endif
   logic        [2:0]     w_rd_chan;
   logic        [ADDR_W-1:0] w_rd_idx;
   logic signed [31:0]    w_p;
   logic signed [17:0]    w_sum;
   logic signed [15:0]    w_y;
   logic signed [18:0]    w_acc_nx;

   function automatic logic [ADDR_W-1:0] dly(input logic [2:0] c);
      return c == 3'd0 ? ADDR_W'(D0) : c == 3'd1 ? ADDR_W'(D1) : c == 3'd2 ? ADDR_W'(D2) :
             c == 3'd3 ? ADDR_W'(D3) : ADDR_W'(D4);
   endfunction

   function automatic logic signed [15:0] sat16(input logic signed [18:0] x);
      return x > 19'sd32767 ? 16'sd32767 : x < -19'sd32768 ? -16'sd32768 : x[15:0];
   endfunction

   // The channel about to be read: 0 when a sample starts, otherwise the next channel.
   // The read offset wraps modulo the per-channel ring size by plain subtraction.
   always_comb begin
      w_rd_chan = r_state == S_IDLE ? 3'd0 : r_chan + 3'd1;
      w_rd_idx  = r_wptr - dly(w_rd_chan);
      w_p       = 32'(FEEDBACK) * 32'(mem_rdata);
      w_sum     = 18'(r_din) + 18'(w_p >>> 15);
      w_y       = sat16(19'(w_sum));
      w_acc_nx  = r_acc + 19'(r_wdata);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_RST;
         r_chan  <= '0;
         r_wptr  <= '0;
         r_acc   <= '0;
         r_din   <= '0;
         r_dout  <= '0;
         r_wdata <= '0;
         r_drop  <= 1'b0;
         r_dv    <= 1'b0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
`ifdef REVERB_SCHED_CLEAR_EN
         r_clr   <= '0;
`endif
      end else begin
         r_drop <= sample_valid && r_state != S_IDLE;
         r_dv   <= 1'b0;
         r_rd   <= 1'b0;
         r_wr   <= 1'b0;
         case (r_state)
            S_IDLE: if (sample_valid) begin
               r_din   <= din;
               r_chan  <= '0;
               r_acc   <= '0;
               r_rd    <= 1'b1;
               r_addr  <= {w_rd_chan, w_rd_idx};
               r_state <= S_READ;
            end
            S_READ: r_state <= S_CALC;
            S_CALC: begin
               r_wr    <= 1'b1;
               r_addr  <= {r_chan, r_wptr};
               r_wdata <= w_y;
               r_state <= S_WRITE;
            end
            // mem_wdata still holds this channel's y, so it feeds the accumulator directly.
            S_WRITE: begin
               r_acc <= w_acc_nx;
               if (r_chan == 3'd4) begin
                  r_dout  <= sat16(w_acc_nx >>> 3);
                  r_dv    <= 1'b1;
                  r_state <= S_OUT;
               end else begin
                  r_chan  <= w_rd_chan;
                  r_rd    <= 1'b1;
                  r_addr  <= {w_rd_chan, w_rd_idx};
                  r_state <= S_READ;
               end
            end
            S_OUT: begin
               r_wptr  <= r_wptr + 1'b1;
               r_state <= S_IDLE;
            end
`ifdef REVERB_SCHED_CLEAR_EN
            // One zero write per cycle; leave once the last address has been issued.
            S_CLEAR: if (r_clr == CLR_N) r_state <= S_IDLE;
            else begin
               r_wr    <= 1'b1;
               r_addr  <= r_clr;
               r_wdata <= '0;
               r_clr   <= r_clr + 1'b1;
            end
`endif
            default: r_state <= S_RST;
         endcase
      end
   end

   assign busy        = r_state != S_IDLE;
   assign sample_drop = r_drop;
   assign dout        = r_dout;
   assign dout_valid  = r_dv;
   assign mem_addr    = r_addr;
   assign mem_rd      = r_rd;
   assign mem_wr      = r_wr;
   assign mem_wdata   = r_wdata;
endmodule

// File: tb/tb_reverb_scheduler.sv
// tb_reverb_scheduler: scoreboard bench for reverb_scheduler with ADDR_W=4 and delays 3/5/7/9/11.
module tb_reverb_scheduler;
   typedef struct {int cyc; int addr; int data;} ev_t;
`ifdef REVERB_SCHED_CLEAR_EN
   localparam int BUSY_RST = 1;
`else
   localparam int BUSY_RST = 0;
`endif
   logic clk = 1'b0, reset = 1'b1, sample_valid = 1'b0;
   logic signed [15:0] din = '0;
   logic signed [15:0] dout, mem_wdata;
   logic signed [15:0] mem_rdata = '0;
   logic busy, sample_drop, dout_valid, mem_rd, mem_wr;
   logic [6:0] mem_addr;
   logic signed [15:0] ram [0:127] = '{default: '0};
   ev_t q_rd[$], q_wr[$], q_out[$];
   ev_t e_mon;
   int mm [0:79] = '{default: 0};
   int dly [5] = '{3, 5, 7, 9, 11};
   int wptr = 0, cyc = 0, n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   reverb_scheduler #(.ADDR_W(4), .D0(3), .D1(5), .D2(7), .D3(9), .D4(11)) dut (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .din(din), .busy(busy),
      .sample_drop(sample_drop), .dout(dout), .dout_valid(dout_valid), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      mem_rdata <= mem_rd ? ram[mem_addr] : 16'sd0;
   end

   task automatic check(input string tag, input logic signed [31:0] got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
   endfunction

   // Reference comb bank; nwr < 5 models a sample aborted by reset after nwr writes.
   task automatic model(input int x, input int nrd, input int nwr, input int c);
      int acc = 0;
      int ra, y;
      for (int k = 0; k < 5; k++) begin
         ra = k * 16 + ((wptr - dly[k]) & 15);
         y = sat(x + ((22937 * mm[ra]) >>> 15));
         if (k < nrd) q_rd.push_back(ev_t'{c + 1 + 3 * k, ra, 0});
         if (k < nwr) begin
            mm[k * 16 + wptr] = y;
            q_wr.push_back(ev_t'{c + 3 + 3 * k, k * 16 + wptr, y});
         end
         acc += y;
      end
      if (nwr == 5) begin
         q_out.push_back(ev_t'{c + 16, 0, sat(acc >>> 3)});
         wptr = (wptr + 1) & 15;
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      #1;
      if (mem_rd) begin
         if (q_rd.size() == 0) check("rd_unexpected", cyc, -1);
         else begin
            e_mon = q_rd.pop_front();
            check("rd_cycle", cyc, e_mon.cyc);
            check("rd_addr", mem_addr, e_mon.addr);
         end
      end
      if (mem_wr) begin
         if (q_wr.size() == 0) check("wr_unexpected", cyc, -1);
         else begin
            e_mon = q_wr.pop_front();
            check("wr_cycle", cyc, e_mon.cyc);
            check("wr_addr", mem_addr, e_mon.addr);
            check("wr_data", mem_wdata, e_mon.data);
         end
      end
      if (dout_valid) begin
         if (q_out.size() == 0) check("dout_unexpected", cyc, -1);
         else begin
            e_mon = q_out.pop_front();
            check("dout_cycle", cyc, e_mon.cyc);
            check("dout_value", dout, e_mon.data);
         end
      end
      if (mem_rd || mem_wr) check("rd_wr_exclusive", mem_rd & mem_wr, 0);
   end

   task automatic do_reset();
      int c;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wptr = 0;
      c = cyc;
      check("rst_busy", busy, BUSY_RST);
      check("rst_drop", sample_drop, 0);
      check("rst_dout", dout, 0);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
`ifdef REVERB_SCHED_CLEAR_EN
      for (int i = 0; i < 80; i++) begin
         mm[i] = 0;
         q_wr.push_back(ev_t'{c + 1 + i, i, 0});
      end
      repeat (10) @(negedge clk);
      sample_valid = 1'b1;
      din = 16'sd1234;
      @(negedge clk);
      sample_valid = 1'b0;
      check("clear_drop", sample_drop, 1);
      repeat (69) @(negedge clk);
      check("clear_busy_last", busy, 1);
      @(negedge clk);
      check("clear_busy_done", busy, 0);
`endif
   endtask

   task automatic send(input logic signed [15:0] x);
      sample_valid = 1'b1;
      din = x;
      model(x, 5, 5, cyc);
      @(negedge clk);
      sample_valid = 1'b0;
      check("busy_start", busy, 1);
      check("no_drop", sample_drop, 0);
      repeat (15) @(negedge clk);
      check("busy_out", busy, 1);
      @(negedge clk);
      check("busy_idle", busy, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      send(16'sd16384);
      check("impulse_dout", dout, 10240);
      repeat (3) send(16'sd0);
      check("echo_dout", dout, 1433);
      repeat (8) send(16'sd0);
      // overrun: second strobe five cycles in is dropped
      sample_valid = 1'b1;
      din = 16'sd1000;
      model(1000, 5, 5, cyc);
      @(negedge clk);
      sample_valid = 1'b0;
      check("ovr_drop_t1", sample_drop, 0);
      repeat (4) @(negedge clk);
      sample_valid = 1'b1;
      din = -16'sd5;
      @(negedge clk);
      sample_valid = 1'b0;
      check("ovr_drop_pulse", sample_drop, 1);
      @(negedge clk);
      check("ovr_drop_end", sample_drop, 0);
      repeat (10) @(negedge clk);
      check("ovr_busy_idle", busy, 0);
      // reset in the middle of a sample: only ch0/ch1 writes and ch0..ch2 reads happen
      sample_valid = 1'b1;
      din = 16'sd2000;
      model(2000, 3, 2, cyc);
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (7) @(negedge clk);
      do_reset();
      send(16'sd3000);
      repeat (3) send(16'sd500);
      repeat (14) send(16'sd32767);
      check("sat_pos_dout", dout, 20479);
      repeat (24) send(-16'sd32768);
      check("sat_neg_dout", dout, -20480);
      repeat (10) send(16'($urandom));
      repeat (5) @(negedge clk);
      check("rd_pending", q_rd.size(), 0);
      check("wr_pending", q_wr.size(), 0);
      check("dout_pending", q_out.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
